// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: RREAD -> MEM -> WBACK -> RETIRE per accepted instruction.
// Optional macro SEQ_MEM_TIMEOUT_EN adds a MEM-phase ack timeout with abort to RETIRE.
module exec_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  input  logic             RegRead,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Branch,
  output logic             rf_rd_en,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             rf_wr_en,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             instr_done,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RREAD  = 3'd1,
    S_MEM    = 3'd2,
    S_WBACK  = 3'd3,
    S_RETIRE = 3'd4
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("exec_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             rw_q, rw_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_c;
  logic             accept_c;

  // Phase that follows RREAD (or IDLE when no register read is needed).
  function automatic state_e phase_after_rread(input logic mem, input logic rw);
    return mem ? S_MEM : (rw ? S_WBACK : S_RETIRE);
  endfunction

  assign accept_c = ctrl_valid && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_valid) begin
          state_d = RegRead ? S_RREAD : phase_after_rread(MemRead | MemWrite, RegWrite);
        end
      end
      S_RREAD:  state_d = phase_after_rread(mr_q | mw_q, rw_q);
      S_MEM: begin
        // A same-cycle ack beats timeout expiry.
        if (mem_ack) begin
          state_d = rw_q ? S_WBACK : S_RETIRE;
        end else if (expire_c) begin
          state_d = S_RETIRE;
        end
      end
      S_WBACK:  state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Latched strobes and retire counter
  always_comb begin
    rr_d  = rr_q;
    rw_d  = rw_q;
    mr_d  = mr_q;
    mw_d  = mw_q;
    br_d  = br_q;
    cnt_d = cnt_q;
    if (accept_c) begin
      rr_d = RegRead;
      rw_d = RegWrite;
      mr_d = MemRead;
      mw_d = MemWrite;
      br_d = Branch;
    end
    if (state_q == S_RETIRE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q  <= 1'b0;
      rw_q  <= 1'b0;
      mr_q  <= 1'b0;
      mw_q  <= 1'b0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      mw_q  <= mw_d;
      br_q  <= br_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned   TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  // Expiry happens in the TIMEOUT_CYCLES-th MEM cycle when no ack is present.
  assign expire_c = (state_q == S_MEM) && !mem_ack && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = expire_c;
    if ((state_d == S_MEM) && (state_q != S_MEM)) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_MEM) && !mem_ack) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign mem_timeout = tmo_flag_q && (state_q == S_RETIRE);
`else
  assign expire_c    = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  // Moore output decode
  always_comb begin
    ctrl_ready    = 1'b0;
    rf_rd_en      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    rf_wr_en      = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      S_IDLE:  ctrl_ready = 1'b1;
      S_RREAD: rf_rd_en   = 1'b1;
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = mw_q;
      end
      S_WBACK: rf_wr_en = 1'b1;
      S_RETIRE: begin
        pc_en         = 1'b1;
        pc_sel_branch = br_q;
        instr_done    = 1'b1;
      end
      default: ctrl_ready = 1'b0;
    endcase
  end

  assign retired_count = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: vector table of instruction classes plus reset/wrap sequences.
module tb_exec_sequencer;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic             reg_read, reg_write, mem_read, mem_write, branch;
  logic             rf_rd_en, mem_req, mem_we, mem_ack, rf_wr_en;
  logic             pc_en, pc_sel_branch, instr_done, mem_timeout;
  logic [CNT_W-1:0] retired_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .RegRead      (reg_read),
    .RegWrite     (reg_write),
    .MemRead      (mem_read),
    .MemWrite     (mem_write),
    .Branch       (branch),
    .rf_rd_en     (rf_rd_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .rf_wr_en     (rf_wr_en),
    .pc_en        (pc_en),
    .pc_sel_branch(pc_sel_branch),
    .instr_done   (instr_done),
    .mem_timeout  (mem_timeout),
    .retired_count(retired_count)
  );

  typedef struct {
    logic rr, rw, mr, mw, br;
    int   ackd;     // MEM cycle index (0-based) at which ack is driven; large = never
    bit   ackout;   // drive mem_ack high outside MEM
    int   e_rd, e_mem, e_we, e_wr, e_done, e_br, e_tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rr, rw, mr, mw, br, input int ackd, input bit ackout,
                              input int e_rd, e_mem, e_we, e_wr, e_done, e_br, e_tmo);
    vec_t v;
    v.rr = rr; v.rw = rw; v.mr = mr; v.mw = mw; v.br = br;
    v.ackd = ackd; v.ackout = ackout;
    v.e_rd = e_rd; v.e_mem = e_mem; v.e_we = e_we; v.e_wr = e_wr;
    v.e_done = e_done; v.e_br = e_br; v.e_tmo = e_tmo;
    return v;
  endfunction

  function automatic int idle_outs_bad();
    return int'({rf_rd_en, mem_req, mem_we, rf_wr_en, pc_en, pc_sel_branch, instr_done, mem_timeout} != 8'd0);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int rd, memc, we, wr, done, brs, tmo, busy_ready;
    rd = 0; memc = 0; we = 0; wr = 0; done = 0; brs = 0; tmo = 0; busy_ready = 0;
    check($sformatf("v%0d_ready_before", idx), int'(ctrl_ready), 1);
    ctrl_valid = 1'b1;
    {reg_read, reg_write, mem_read, mem_write, branch} = {v.rr, v.rw, v.mr, v.mw, v.br};
    mem_ack = v.ackout;
    tick();
    // Strobes and valid after acceptance must be ignored.
    ctrl_valid = 1'b0;
    {reg_read, reg_write, mem_read, mem_write, branch} = 5'b11111;
    for (int n = 1; n <= 60; n++) begin
      if (mem_req) begin
        memc++;
        if (mem_we) we = 1;
        mem_ack = ((memc - 1) == v.ackd);
      end else begin
        mem_ack = v.ackout;
      end
      if (rf_rd_en) rd++;
      if (rf_wr_en) wr++;
      if (ctrl_ready) busy_ready++;
      if (instr_done) begin
        done = n;
        brs  = int'(pc_sel_branch);
        tmo  = int'(mem_timeout);
        if (!pc_en) busy_ready++;
        break;
      end
      tick();
    end
    mem_ack = 1'b0;
    {reg_read, reg_write, mem_read, mem_write, branch} = 5'b00000;
    check($sformatf("v%0d_rd_cycles", idx), rd, v.e_rd);
    check($sformatf("v%0d_mem_cycles", idx), memc, v.e_mem);
    check($sformatf("v%0d_mem_we", idx), we, v.e_we);
    check($sformatf("v%0d_wr_cycles", idx), wr, v.e_wr);
    check($sformatf("v%0d_done_cycle", idx), done, v.e_done);
    check($sformatf("v%0d_pc_sel_branch", idx), brs, v.e_br);
    check($sformatf("v%0d_mem_timeout", idx), tmo, v.e_tmo);
    check($sformatf("v%0d_ready_busy", idx), busy_ready, 0);
    tick();
    exp_count = (exp_count + 1) % 4;
    check($sformatf("v%0d_ready_after", idx), int'(ctrl_ready), 1);
    check($sformatf("v%0d_count", idx), int'(retired_count), exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_exp[5];
    wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0; wrap_exp[4] = 1;

    //            rr rw mr mw br ackd ackout  rd mem we wr done br tmo
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,    0, 0,  0, 0, 1,   0, 0)); // no-op
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0,    1, 0,  0, 1, 3,   0, 0)); // add
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,  0,    1, 1,  0, 1, 4,   0, 0)); // load, ack first cycle
    vecs.push_back(mk(1, 1, 1, 0, 0, 3,  0,    1, 4,  0, 1, 7,   0, 0)); // load, ack delayed 3
    vecs.push_back(mk(1, 0, 0, 1, 0, 1,  0,    1, 2,  1, 0, 4,   0, 0)); // store
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0,    0, 0,  0, 0, 1,   1, 0)); // unconditional branch
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0,    1, 0,  0, 0, 2,   1, 0)); // conditional branch
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1,    0, 1,  1, 0, 2,   0, 0)); // read+write = write, stray acks
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  1,    1, 0,  0, 1, 3,   0, 0)); // stray acks with no MEM
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0,    0, 0,  0, 1, 2,   0, 0)); // write-back only
`ifdef SEQ_MEM_TIMEOUT_EN
    vecs.push_back(mk(1, 1, 1, 0, 0, 99, 0,    1, 4,  0, 0, 6,   0, 1)); // no ack: timeout
    vecs.push_back(mk(1, 1, 1, 0, 0, 3,  0,    1, 4,  0, 1, 7,   0, 0)); // ack on expiry cycle wins
`endif

    // Reset with ctrl_valid held: nothing accepted until rst_n is released.
    rst_n = 1'b0; ctrl_valid = 1'b1; mem_ack = 1'b0;
    {reg_read, reg_write, mem_read, mem_write, branch} = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_ready", i), int'(ctrl_ready), 1);
      check($sformatf("rst%0d_outputs", i), idle_outs_bad(), 0);
      check($sformatf("rst%0d_count", i), int'(retired_count), 0);
    end
    rst_n = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    check("rst_release_done", int'(instr_done), 1);
    check("rst_release_ready", int'(ctrl_ready), 0);
    tick();
    exp_count = 1;
    check("rst_release_count", int'(retired_count), 1);
    check("rst_release_idle", idle_outs_bad(), 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Counter wrap from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("wrap_reset_count", int'(retired_count), 0);
    for (int i = 0; i < 5; i++) begin
      ctrl_valid = 1'b1;
      tick();
      ctrl_valid = 1'b0;
      tick();
      check($sformatf("wrap%0d_count", i), int'(retired_count), wrap_exp[i]);
    end

    // Reset during a MEM stall; a late ack must not resurrect the transaction.
    ctrl_valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
    tick();
    ctrl_valid = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
    tick();
    check("midmem_req_before", int'(mem_req), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midmem_req_dropped", int'(mem_req), 0);
    check("midmem_ready", int'(ctrl_ready), 1);
    check("midmem_count", int'(retired_count), 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late_ack_outputs", idle_outs_bad(), 0);
    check("late_ack_ready", int'(ctrl_ready), 1);
    tick();
    check("late_ack_done", int'(instr_done), 0);
    check("late_ack_count", int'(retired_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
